mux32_2to1_reg: RTL and testbench
=================================

// Module: mux32_2to1_reg
// PURPOSE
//   32-bit, 2-input word selector for datapath steering (ALU operand / writeback select).
//   op=0 passes input a and op=1 passes input b on a combinational output.
//   A registered copy of the selected word is also provided for pipelined consumers.
//   Single clock domain; asynchronous active-low reset affects the registered copy only.
// PARAMETERS
//   WIDTH      32   data width of a, b, result, result_q (must be >= 1)
//   REG_EN_DEF 1'b1 value loaded into the internal capture-enable flag at reset
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous reset, active low
//   a         in   WIDTH  data input, selected when op=0
//   b         in   WIDTH  data input, selected when op=1
//   op        in   1      select: 0 -> a, 1 -> b
//   cap_en    in   1      capture enable for result_q (1 = load on clock edge)
//   result    out  WIDTH  combinational selected word
//   result_q  out  WIDTH  registered selected word
//   q_valid   out  1      result_q holds data captured since the last reset
// BEHAVIOUR
//   - result = op ? b : a, purely combinational, zero latency, bit-for-bit copy.
//     Independent of clk, rst_n and cap_en.
//   - op is X/Z (simulation only): result is X on every bit where a and b differ.
//     Bits where a and b are equal pass through unchanged.
//   - rst_n low: result_q <= 0 and q_valid <= 0 immediately, without waiting for a clock edge.
//   - rst_n deasserted: first rising clk edge with cap_en=1 loads result_q <= result and q_valid <= 1.
//   - cap_en=0: result_q and q_valid hold their values.
//   - Latency op/a/b -> result_q is 1 cycle.
//   - Reset asserted mid-operation clears result_q at once and overrides cap_en.
//   - Reset released at a clock edge: that edge does not capture; capture starts on the next edge.
//   - No arithmetic, sign handling or width conversion: all data ports are exactly WIDTH bits.
//   - op changing in the same cycle as capture: result_q takes the value selected by op
//     as sampled at that edge.
// STRUCTURE
//   - Shared package mux_pkg holds:
//       localparam DATA_W = 32;
//       localparam logic SEL_A = 1'b0;
//       localparam logic SEL_B = 1'b1;
//   - One sub-module, mux1_2to1 (ports a, b, sel, y: 1-bit), instantiated WIDTH times
//     in a generate loop to build result.
//   - The capture register and q_valid live in the top-level always block,
//     which is sensitive to posedge clk / negedge rst_n.
// TESTING
//   1. a=32'h0000_0043, b=32'h8000_007F, op=0 -> result=32'h0000_0043 in the same delta.
//      After a clk edge with cap_en=1: result_q=32'h0000_0043, q_valid=1.
//   2. Same a and b, op=1 -> result=32'h8000_007F.
//      Next edge: result_q=32'h8000_007F, confirming MSB and low bits are routed.
//   3. rst_n=0 between clock edges while result_q=32'h8000_007F
//      -> result_q=0 and q_valid=0 immediately; result still tracks op/a/b.
//   4. cap_en=0 while toggling op over 3 edges -> result follows each op value;
//      result_q and q_valid stay unchanged.
//   5. a=32'hFFFF_FFFF, b=32'h0000_0000, op toggled every cycle
//      -> result alternates FFFF_FFFF/0000_0000; result_q lags by exactly 1 cycle.
//   6. Walking-one on a and b (bit i set, i=0..31) under both op values
//      -> result has only bit i set when the selected input carries it; no cross-bit leakage.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the word-select datapath: default width and select encodings.
package mux_pkg;

  localparam int   DATA_W = 32;
  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_B  = 1'b1;

endpackage

// File: rtl/mux1_2to1.sv
// Single-bit 2:1 selector; an unknown sel yields X only where a and b differ.
module mux1_2to1
  import mux_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux32_2to1_reg.sv
// WIDTH-bit 2:1 word selector with a combinational output and a registered,
// capture-enabled copy of the selected word plus a valid flag.
module mux32_2to1_reg
  import mux_pkg::*;
#(
  parameter int   WIDTH      = DATA_W,
  parameter logic REG_EN_DEF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cap_en,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
  output logic             q_valid
);

  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic             valid_q;
  logic             valid_d;
  logic             en_q;
  logic             en_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      mux1_2to1 u_bit (
        .a   (a[gi]),
        .b   (b[gi]),
        .sel (op),
        .y   (result[gi])
      );
    end
  endgenerate

  // en_q starts at REG_EN_DEF after reset and is forced high from the first edge on,
  // so REG_EN_DEF=0 suppresses only the first post-reset capture.
  always_comb begin
    cap_d   = cap_q;
    valid_d = valid_q;
    en_d    = 1'b1;
    if (cap_en && en_q) begin
      cap_d   = result;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      valid_q <= 1'b0;
      en_q    <= REG_EN_DEF;
    end else begin
      cap_q   <= cap_d;
      valid_q <= valid_d;
      en_q    <= en_d;
    end
  end

  assign result_q = cap_q;
  assign q_valid  = valid_q;

endmodule

// File: tb/tb_mux32_2to1_reg.sv
// Directed self-checking bench for mux32_2to1_reg: combinational select,
// registered capture, async reset, capture hold and walking-one isolation.
module tb_mux32_2to1_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        cap_en;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        q_valid;

  int total;
  int bad;

  mux32_2to1_reg #(
    .WIDTH      (32),
    .REG_EN_DEF (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .cap_en   (cap_en),
    .result   (result),
    .result_q (result_q),
    .q_valid  (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Inputs change at the falling edge; checks run 1ns later, clear of the rising edge.
  task automatic step_to_negedge();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q;
    logic [31:0] one;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    a      = 32'h0000_0043;
    b      = 32'h8000_007F;
    op     = 1'b0;
    cap_en = 1'b1;
    #1;
    chk("reset_result_q", result_q, 32'h0);
    chk("reset_q_valid", {31'b0, q_valid}, 32'h0);
    chk("reset_result_comb", result, 32'h0000_0043);
    tick();
    chk("reset_holds_over_edge", result_q, 32'h0);

    // 1: op=0 selects a
    step_to_negedge();
    rst_n = 1'b1;
    #1;
    chk("t1_result", result, 32'h0000_0043);
    chk("t1_q_before_edge", result_q, 32'h0);
    tick();
    chk("t1_result_q", result_q, 32'h0000_0043);
    chk("t1_q_valid", {31'b0, q_valid}, 32'h1);

    // 2: op=1 selects b
    step_to_negedge();
    op = 1'b1;
    #1;
    chk("t2_result", result, 32'h8000_007F);
    tick();
    chk("t2_result_q", result_q, 32'h8000_007F);

    // 3: async reset between edges
    step_to_negedge();
    rst_n = 1'b0;
    #1;
    chk("t3_result_q_cleared", result_q, 32'h0);
    chk("t3_q_valid_cleared", {31'b0, q_valid}, 32'h0);
    chk("t3_result_tracks", result, 32'h8000_007F);
    op = 1'b0;
    #1;
    chk("t3_result_tracks_op", result, 32'h0000_0043);
    tick();
    chk("t3_reset_overrides_cap_en", result_q, 32'h0);
    step_to_negedge();
    rst_n = 1'b1;
    tick();
    chk("t3_capture_after_release", result_q, 32'h0000_0043);
    chk("t3_valid_after_release", {31'b0, q_valid}, 32'h1);

    // 4: cap_en=0 holds while op toggles
    for (int k = 0; k < 3; k++) begin
      step_to_negedge();
      cap_en = 1'b0;
      op     = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("t4_result_%0d", k), result, (k % 2 == 0) ? 32'h8000_007F : 32'h0000_0043);
      tick();
      chk($sformatf("t4_hold_q_%0d", k), result_q, 32'h0000_0043);
      chk($sformatf("t4_hold_valid_%0d", k), {31'b0, q_valid}, 32'h1);
    end

    // 5: all-ones / all-zeros alternating; result_q lags by one cycle
    step_to_negedge();
    cap_en = 1'b1;
    a      = 32'hFFFF_FFFF;
    b      = 32'h0000_0000;
    exp_q  = 32'h0000_0043;
    for (int k = 0; k < 4; k++) begin
      op = (k % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("t5_result_%0d", k), result, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("t5_lag_%0d", k), result_q, exp_q);
      tick();
      exp_q = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      chk($sformatf("t5_result_q_%0d", k), result_q, exp_q);
      step_to_negedge();
    end

    // 6: walking one, no cross-bit leakage
    for (int i = 0; i < 32; i++) begin
      one = 32'h1 << i;
      a  = one;
      b  = 32'h0;
      op = 1'b0;
      #1;
      chk($sformatf("t6_a_sel_bit%0d", i), result, one);
      op = 1'b1;
      #1;
      chk($sformatf("t6_a_unsel_bit%0d", i), result, 32'h0);
      a = 32'h0;
      b = one;
      #1;
      chk($sformatf("t6_b_sel_bit%0d", i), result, one);
      op = 1'b0;
      #1;
      chk($sformatf("t6_b_unsel_bit%0d", i), result, 32'h0);
    end
    step_to_negedge();
    a  = 32'h0;
    b  = 32'h0001_0000;
    op = 1'b1;
    tick();
    chk("t6_capture_bit16", result_q, 32'h0001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
